mmio_timer_responder: RTL and testbench

- Memory-mapped timer peripheral; the responder end of the MEM stage's d_valid/d_ready/d_rdata data-bus handshake.
- Decodes a fixed address window and serves 64-bit register reads and writes after a configurable latency.
- Runs a free-running 64-bit cycle counter with a compare match.
- Drives one interrupt line into a bit of the core's interrupt_sources vector.

---
 rtl/mmio_timer_responder.sv | 206 ++++++++++++++++++++
 tb/tb_mmio_timer_responder.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer_responder.sv
// mmio_timer_responder: memory-mapped 64-bit timer with compare-match interrupt,
// acting as the responder on the d_valid/d_ready/d_rdata data bus.
//
// Optional feature macro: TIMER_AUTORELOAD_EN
//   defined   -> PERIOD (offset 0x20) is RW and every match with PERIOD != 0
//                advances COMPARE by PERIOD, giving periodic interrupts.
//   undefined -> PERIOD reads 0, writes are ignored.
//
// Handshake: the initiator raises d_valid and holds d_addr/d_wdata/d_we stable
// until d_ready. d_ready is a one-cycle strobe RESP_LATENCY cycles after the
// accept edge; d_rdata carries the read data only while d_ready = 1 and is 0
// otherwise. Requests outside the 64-byte window are never acknowledged.
module mmio_timer_responder #(
    parameter logic [63:0] BASE_ADDR    = 64'hFFFF_0000,
    parameter int unsigned RESP_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        d_valid,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic        d_we,
    output logic        d_ready,
    output logic [63:0] d_rdata,
    output logic        irq,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Wait-counter preload: BUSY lasts RESP_LATENCY-1 cycles before RESP.
    localparam logic [3:0] WAIT_LOAD = (RESP_LATENCY > 1) ? 4'(RESP_LATENCY - 2) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [63:0] hold_q, hold_d;
    logic        d_ready_q, d_ready_d;
    logic [63:0] d_rdata_q, d_rdata_d;

    logic [63:0] count_q, count_d;
    logic [63:0] compare_q, compare_d;
    logic        enable_q, enable_d;
    logic        irq_en_q, irq_en_d;
    logic        pending_q, pending_d;
`ifdef TIMER_AUTORELOAD_EN
    logic [63:0] period_q, period_d;
`endif

    logic        sel;
    logic        accept;
    logic        wr;
    logic [2:0]  off;
    logic        match;
    logic [63:0] rd_val;
    logic        unused_addr_bits;

    // Byte-lane address bits carry no meaning: registers are whole 64-bit words.
    assign unused_addr_bits = ^d_addr[2:0];

    assign sel    = d_valid & (d_addr[63:6] == BASE_ADDR[63:6]);
    assign off    = d_addr[5:3];
    assign accept = (state_q == ST_IDLE) & sel;
    assign wr     = accept & d_we;
    assign match  = enable_q & (count_q == compare_q);

    // Register read mux, sampled in the accept cycle.
    always_comb begin
        rd_val = 64'd0;
        case (off)
            3'd0: rd_val = count_q;
            3'd1: rd_val = compare_q;
            3'd2: rd_val = {62'd0, irq_en_q, enable_q};
            3'd3: rd_val = {63'd0, pending_q};
`ifdef TIMER_AUTORELOAD_EN
            3'd4: rd_val = period_q;
`endif
            default: rd_val = 64'd0;
        endcase
    end

    // Timer register next-state: software writes commit on the accept edge.
    always_comb begin
        count_d = count_q;
        if (enable_q) begin
            count_d = count_q + 64'd1;
        end
        if (wr && off == 3'd0) begin
            count_d = d_wdata;
        end

        compare_d = compare_q;
`ifdef TIMER_AUTORELOAD_EN
        if (match && period_q != 64'd0) begin
            compare_d = compare_q + period_q;
        end
`endif
        if (wr && off == 3'd1) begin
            compare_d = d_wdata;
        end

        enable_d = enable_q;
        irq_en_d = irq_en_q;
        if (wr && off == 3'd2) begin
            enable_d = d_wdata[0];
            irq_en_d = d_wdata[1];
        end

        // A match on the same edge as a W1C clear keeps the flag set.
        pending_d = pending_q;
        if (wr && off == 3'd3 && d_wdata[0]) begin
            pending_d = 1'b0;
        end
        if (match) begin
            pending_d = 1'b1;
        end

`ifdef TIMER_AUTORELOAD_EN
        period_d = period_q;
        if (wr && off == 3'd4) begin
            period_d = d_wdata;
        end
`endif
    end

    // Response FSM next-state: accept, wait out the latency, strobe d_ready once.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        hold_d    = hold_q;
        d_ready_d = 1'b0;
        d_rdata_d = 64'd0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    hold_d = d_we ? 64'd0 : rd_val;
                    if (RESP_LATENCY <= 1) begin
                        state_d   = ST_RESP;
                        d_ready_d = 1'b1;
                        d_rdata_d = d_we ? 64'd0 : rd_val;
                    end else begin
                        state_d = ST_BUSY;
                        wait_d  = WAIT_LOAD;
                    end
                end
            end
            ST_BUSY: begin
                if (wait_q == 4'd0) begin
                    state_d   = ST_RESP;
                    d_ready_d = 1'b1;
                    d_rdata_d = hold_q;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state, cleared asynchronously so an in-flight request is dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            wait_q    <= 4'd0;
            hold_q    <= 64'd0;
            d_ready_q <= 1'b0;
            d_rdata_q <= 64'd0;
            count_q   <= 64'd0;
            compare_q <= 64'd0;
            enable_q  <= 1'b0;
            irq_en_q  <= 1'b0;
            pending_q <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
            period_q  <= 64'd0;
`endif
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            hold_q    <= hold_d;
            d_ready_q <= d_ready_d;
            d_rdata_q <= d_rdata_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            enable_q  <= enable_d;
            irq_en_q  <= irq_en_d;
            pending_q <= pending_d;
`ifdef TIMER_AUTORELOAD_EN
            period_q  <= period_d;
`endif
        end
    end

    assign d_ready   = d_ready_q;
    assign d_rdata   = d_rdata_q;
    assign irq       = pending_q & irq_en_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Bench for mmio_timer_responder: one instance with RESP_LATENCY = 1 (timer
// features, with an arithmetic COUNT/COMPARE model) and one with RESP_LATENCY = 3
// (latency, window decode, back-to-back and mid-transaction reset).
module tb_mmio_timer_responder;

    localparam logic [63:0] BASE = 64'hFFFF_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        v1 = 1'b0;
    logic        v3 = 1'b0;
    logic [63:0] d_addr = 64'd0;
    logic [63:0] d_wdata = 64'd0;
    logic        d_we = 1'b0;
    logic        rdy1, rdy3, irq1, irq3;
    logic [63:0] rdat1, rdat3;
    logic [1:0]  st1, st3;

    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc = 0;

    // Reference model for the latency-1 instance: COUNT is base + elapsed edges.
    logic [63:0] m_base, m_compare, m_period;
    longint      m_base_edge;
    bit          m_en, m_irq_en;
    logic [63:0] exp_q[$];

    mmio_timer_responder #(.BASE_ADDR(BASE), .RESP_LATENCY(1)) u_dut1 (
        .clock(clock), .reset(reset), .d_valid(v1), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_we(d_we), .d_ready(rdy1), .d_rdata(rdat1), .irq(irq1), .dbg_state(st1)
    );

    mmio_timer_responder #(.BASE_ADDR(BASE), .RESP_LATENCY(3)) u_dut3 (
        .clock(clock), .reset(reset), .d_valid(v3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_we(d_we), .d_ready(rdy3), .d_rdata(rdat3), .irq(irq3), .dbg_state(st3)
    );

    // Clock and edge counter (cyc = number of rising edges so far).
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] addr_of(input logic [2:0] off);
        logic [63:0] a;
        a = BASE + {58'd0, off, 3'd0};
        a[2:0] = 3'($urandom_range(0, 7));
        return a;
    endfunction

    function automatic logic rdy_of(input int lat);
        return (lat == 1) ? rdy1 : rdy3;
    endfunction

    function automatic logic [63:0] rdata_of(input int lat);
        return (lat == 1) ? rdat1 : rdat3;
    endfunction

    function automatic logic [63:0] cnt_after(input longint e);
        return m_base + (m_en ? 64'(e - m_base_edge) : 64'd0);
    endfunction

    // Value a read accepted at edge acc must return.
    function automatic logic [63:0] exp_read(input logic [2:0] off, input longint acc);
        case (off)
            3'd0: return cnt_after(acc - 1);
            3'd1: return m_compare;
            3'd2: return {62'd0, m_irq_en, m_en};
`ifdef TIMER_AUTORELOAD_EN
            3'd4: return m_period;
`endif
            default: return 64'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_base = 64'd0; m_compare = 64'd0; m_period = 64'd0;
        m_base_edge = cyc; m_en = 1'b0; m_irq_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One bus transfer, started at a negedge with the target idle.
    task automatic xfer(input int lat, input bit we, input logic [63:0] addr,
                        input logic [63:0] wdata, output logic [63:0] rdata, output longint acc);
        int k;
        bit seen;
        d_addr = addr; d_wdata = wdata; d_we = we;
        if (lat == 1) v1 = 1'b1; else v3 = 1'b1;
        acc = cyc + 1;
        seen = 1'b0; k = 0; rdata = 64'd0;
        while (!seen && k < 40) begin
            @(negedge clock);
            k++;
            if (rdy_of(lat) === 1'b1) begin
                seen = 1'b1;
                rdata = rdata_of(lat);
            end
        end
        v1 = 1'b0; v3 = 1'b0;
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL xfer_timeout lat=%0d addr=%h: no d_ready in 40 cycles, required after %0d", lat, addr, lat);
        end else if (k != lat) begin
            n_bad++;
            $display("FAIL latency lat=%0d addr=%h: d_ready after %0d cycles, required %0d", lat, addr, k, lat);
        end
        @(negedge clock);
        n_cmp++;
        if (rdy_of(lat) !== 1'b0 || rdata_of(lat) !== 64'd0) begin
            n_bad++;
            $display("FAIL strobe_width lat=%0d: d_ready=%b d_rdata=%h one cycle later, required 0/0", lat, rdy_of(lat), rdata_of(lat));
        end
    endtask

    task automatic wr1(input logic [2:0] off, input logic [63:0] data, output longint acc);
        logic [63:0] unused_rd;
        xfer(1, 1'b1, addr_of(off), data, unused_rd, acc);
        case (off)
            3'd0: begin m_base = data; m_base_edge = acc; end
            3'd1: m_compare = data;
            3'd2: begin
                m_base = cnt_after(acc); m_base_edge = acc;
                m_en = data[0]; m_irq_en = data[1];
            end
`ifdef TIMER_AUTORELOAD_EN
            3'd4: m_period = data;
`endif
            default: ;
        endcase
    endtask

    task automatic rd1(input logic [2:0] off, output logic [63:0] data, output longint acc);
        xfer(1, 1'b0, addr_of(off), 64'd0, data, acc);
    endtask

    task automatic wait_irq(output longint at, output bit ok);
        int k;
        ok = 1'b0; at = -1; k = 0;
        while (!ok && k < 100) begin
            @(negedge clock);
            k++;
            if (irq1 === 1'b1) begin ok = 1'b1; at = cyc; end
        end
    endtask

    task automatic test_reset();
        logic [63:0] d;
        longint acc;
        reset = 1'b0;
        idle(3);
        reset = 1'b1;
        model_reset();
        idle(5);
        n_cmp++;
        if ({rdy1, rdy3, irq1, irq3} !== 4'b0 || rdat1 !== 64'd0 || rdat3 !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_idle: rdy=%b%b irq=%b%b rdata=%h/%h, required all 0", rdy1, rdy3, irq1, irq3, rdat1, rdat3);
        end
        rd1(3'd0, d, acc);
        n_cmp++;
        if (d !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_count: COUNT=%h, required 0", d);
        end
    endtask

    task automatic test_latency3_window();
        logic [63:0] d;
        longint acc;
        logic [63:0] bad_addr[3];
        int hold[3];
        bit seen;
        xfer(3, 1'b0, addr_of(3'd2), 64'd0, d, acc);
        n_cmp++;
        if (d !== 64'd0) begin
            n_bad++;
            $display("FAIL lat3_ctrl: CTRL=%h, required 0", d);
        end
        bad_addr[0] = BASE + 64'h100; hold[0] = 20;
        bad_addr[1] = BASE - 64'd8;   hold[1] = 8;
        bad_addr[2] = {$urandom | 32'h100, BASE[31:6], 6'($urandom_range(0, 63))}; hold[2] = 8;
        for (int i = 0; i < 3; i++) begin
            d_addr = bad_addr[i]; d_we = 1'b0; v1 = 1'b1; v3 = 1'b1;
            seen = 1'b0;
            for (int c = 0; c < hold[i]; c++) begin
                @(negedge clock);
                if (rdy1 !== 1'b0 || rdy3 !== 1'b0) seen = 1'b1;
            end
            v1 = 1'b0; v3 = 1'b0;
            n_cmp++;
            if (seen) begin
                n_bad++;
                $display("FAIL out_of_window addr=%h: d_ready seen, required never", bad_addr[i]);
            end
            idle(1);
        end
    endtask

    task automatic test_random();
        logic [63:0] d, e;
        longint acc;
        logic [2:0] off;
        int op;
        wr1(3'd1, rnd64(), acc);
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 9);
            case (op)
                0: wr1(3'd0, rnd64(), acc);
                1: wr1(3'd1, rnd64(), acc);
                2: wr1(3'd2, rnd64(), acc);
                3: wr1(3'($urandom_range(5, 7)), rnd64(), acc);
                default: begin
                    off = 3'($urandom_range(0, 6));
                    if (off == 3'd3) off = 3'd7;
                    exp_q.push_back(exp_read(off, cyc + 1));
                    rd1(off, d, acc);
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (d !== e) begin
                        n_bad++;
                        $display("FAIL random_read off=%0d: got %h, required %h", off, d, e);
                    end
                end
            endcase
            idle($urandom_range(0, 2));
        end
    endtask

    task automatic test_match_irq();
        logic [63:0] d;
        longint acc, acc_e, at, target;
        bit ok;
        wr1(3'd2, 64'd0, acc);
        wr1(3'd1, 64'd10, acc);
        wr1(3'd0, 64'd0, acc);
        wr1(3'd3, 64'd1, acc);
        n_cmp++;
        if (irq1 !== 1'b0) begin
            n_bad++;
            $display("FAIL irq_pre: irq=%b, required 0", irq1);
        end
        wr1(3'd2, 64'd3, acc_e);
        wait_irq(at, ok);
        n_cmp++;
        if (!ok || at != acc_e + 11) begin
            n_bad++;
            $display("FAIL irq_rise: rose at edge %0d (ok=%0d), required %0d", at, ok, acc_e + 11);
        end
        rd1(3'd3, d, acc);
        n_cmp++;
        if (d !== 64'd1) begin
            n_bad++;
            $display("FAIL status_pending: STATUS=%h, required 1", d);
        end
        wr1(3'd3, 64'd1, acc);
        n_cmp++;
        if (irq1 !== 1'b0) begin
            n_bad++;
            $display("FAIL w1c_clear: irq=%b, required 0", irq1);
        end
        wr1(3'd0, 64'd0, acc);
        target = acc + 11;
        while (cyc + 1 < target) @(negedge clock);
        wr1(3'd3, 64'd1, acc);
        n_cmp++;
        if (irq1 !== 1'b1) begin
            n_bad++;
            $display("FAIL set_beats_clear: irq=%b, required 1", irq1);
        end
        rd1(3'd3, d, acc);
        n_cmp++;
        if (d !== 64'd1) begin
            n_bad++;
            $display("FAIL set_beats_clear_status: STATUS=%h, required 1", d);
        end
        wr1(3'd3, 64'd1, acc);
    endtask

    task automatic test_wrap();
        logic [63:0] d, e;
        longint acc;
        wr1(3'd0, 64'hFFFF_FFFF_FFFF_FFFE, acc);
        idle(1);
        for (int i = 0; i < 4; i++) begin
            rd1(3'd0, d, acc);
            e = exp_read(3'd0, acc);
            n_cmp++;
            if (d !== e) begin
                n_bad++;
                $display("FAIL wrap_read%0d: COUNT=%h, required %h", i, d, e);
            end
            idle($urandom_range(0, 1));
        end
        wr1(3'd0, 64'd5, acc);
        idle($urandom_range(0, 6));
        rd1(3'd0, d, acc);
        e = exp_read(3'd0, acc);
        n_cmp++;
        if (d !== e) begin
            n_bad++;
            $display("FAIL count_write: COUNT=%h, required %h", d, e);
        end
    endtask

    task automatic test_period();
        logic [63:0] d, e;
        longint acc, acc_e, at;
        bit ok;
`ifdef TIMER_AUTORELOAD_EN
        wr1(3'd2, 64'd2, acc);
        wr1(3'd0, 64'd0, acc);
        wr1(3'd1, 64'd4, acc);
        wr1(3'd4, 64'd4, acc);
        wr1(3'd3, 64'd1, acc);
        n_cmp++;
        if (irq1 !== 1'b0) begin
            n_bad++;
            $display("FAIL period_pre: irq=%b, required 0", irq1);
        end
        wr1(3'd2, 64'd3, acc_e);
        for (int k = 1; k <= 3; k++) begin
            wait_irq(at, ok);
            n_cmp++;
            if (!ok || at != acc_e + 4 * k + 1) begin
                n_bad++;
                $display("FAIL autoreload_match%0d: edge %0d (ok=%0d), required %0d", k, at, ok, acc_e + 4 * k + 1);
            end
            wr1(3'd3, 64'd1, acc);
            n_cmp++;
            if (irq1 !== 1'b0) begin
                n_bad++;
                $display("FAIL autoreload_clear%0d: irq=%b, required 0", k, irq1);
            end
        end
        rd1(3'd1, d, acc);
        e = 64'd4 + 64'd4 * 64'((acc - acc_e - 2) / 4);
        n_cmp++;
        if (d !== e) begin
            n_bad++;
            $display("FAIL autoreload_compare: COMPARE=%h, required %h", d, e);
        end
        wr1(3'd2, 64'd0, acc);
`else
        wr1(3'd4, 64'd4, acc);
        rd1(3'd4, d, acc);
        n_cmp++;
        if (d !== 64'd0) begin
            n_bad++;
            $display("FAIL period_absent: PERIOD=%h, required 0", d);
        end
        rd1(3'd1, d, acc);
        e = m_compare;
        n_cmp++;
        if (d !== e) begin
            n_bad++;
            $display("FAIL compare_static: COMPARE=%h, required %h", d, e);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [63:0] d, e, v;
        longint acc;
        for (int i = 0; i < 6; i++) begin
            v = rnd64();
            xfer(3, 1'b1, addr_of(3'd1), v, d, acc);
            xfer(3, 1'b1, addr_of(3'($urandom_range(5, 7))), rnd64(), d, acc);
            exp_q.push_back(v);
            xfer(3, 1'b0, addr_of(3'd1), 64'd0, d, acc);
            e = exp_q.pop_front();
            n_cmp++;
            if (d !== e) begin
                n_bad++;
                $display("FAIL b2b_compare%0d: COMPARE=%h, required %h", i, d, e);
            end
            exp_q.push_back(64'd0);
            xfer(3, 1'b0, addr_of(3'($urandom_range(5, 7))), 64'd0, d, acc);
            e = exp_q.pop_front();
            n_cmp++;
            if (d !== e) begin
                n_bad++;
                $display("FAIL b2b_unused%0d: read %h, required %h", i, d, e);
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [63:0] d;
        longint acc;
        bit seen;
        d_addr = BASE + 64'h8; d_wdata = 64'h55; d_we = 1'b1; v3 = 1'b1;
        @(posedge clock);
        #2;
        reset = 1'b0;
        v3 = 1'b0;
        #1;
        n_cmp++;
        if ({rdy1, rdy3, irq1, irq3} !== 4'b0 || rdat1 !== 64'd0 || rdat3 !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: rdy=%b%b irq=%b%b rdata=%h/%h, required all 0", rdy1, rdy3, irq1, irq3, rdat1, rdat3);
        end
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (rdy3 !== 1'b0) seen = 1'b1;
        end
        reset = 1'b1;
        model_reset();
        idle(2);
        n_cmp++;
        if (seen || rdy3 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_drop: d_ready seen for dropped write, required none");
        end
        xfer(3, 1'b0, addr_of(3'd1), 64'd0, d, acc);
        n_cmp++;
        if (d !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_compare: COMPARE=%h, required 0", d);
        end
        rd1(3'd2, d, acc);
        n_cmp++;
        if (d !== 64'd0 || irq1 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: CTRL=%h irq=%b, required 0/0", d, irq1);
        end
    endtask

    initial begin
        test_reset();
        test_latency3_window();
        test_random();
        test_match_irq();
        test_wrap();
        test_period();
        test_back_to_back();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
